// File: rtl/cross_bar_bank_arbiter_if.sv
// Request/response bundle between the three mcash channels, one bank arbiter and its bank HTU.
interface cross_bar_bank_arbiter_if;
  logic [2:0]   ch_req_valid_i;
  logic [5:0]   ch_req_op_i;
  logic [83:0]  ch_req_addr_i;
  logic [383:0] ch_req_data_i;
  logic [2:0]   ch_grant_o;
  logic         xbar_htu_valid_o;
  logic         xbar_htu_allowIn_i;
  logic [1:0]   xbar_htu_ch_id_o;
  logic [1:0]   xbar_htu_opcode_o;
  logic [27:0]  xbar_htu_addr_o;
  logic [127:0] xbar_htu_data_o;
  logic [7:0]   xbar_htu_wbuffer_id_o;
  logic [2:0]   rob_pop_i;
  logic         credit_err_o;

  modport master (
    output ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i, xbar_htu_allowIn_i, rob_pop_i,
    input  ch_grant_o, xbar_htu_valid_o, xbar_htu_ch_id_o, xbar_htu_opcode_o, xbar_htu_addr_o,
           xbar_htu_data_o, xbar_htu_wbuffer_id_o, credit_err_o
  );

  modport slave (
    input  ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i, xbar_htu_allowIn_i, rob_pop_i,
    output ch_grant_o, xbar_htu_valid_o, xbar_htu_ch_id_o, xbar_htu_opcode_o, xbar_htu_addr_o,
           xbar_htu_data_o, xbar_htu_wbuffer_id_o, credit_err_o
  );
endinterface

// File: rtl/cross_bar_bank_arbiter.sv
// Per-bank round-robin scheduler: picks one of three channel requests per cycle into a
// registered HTU stage, with per-channel read credits and write-buffer tagging.
module cross_bar_bank_arbiter_credit #(
  parameter int RD_CREDITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       err_set
);
  localparam logic [3:0] MAX = 4'(RD_CREDITS);

  // A return with nothing outstanding is a protocol error; the counter saturates.
  assign err_set = inc & ~dec & (cnt == MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i)                           cnt <= MAX;
    else if (inc & ~dec & (cnt != MAX)) cnt <= cnt + 4'd1;
    else if (dec & ~inc)                cnt <= cnt - 4'd1;
  end
endmodule

module cross_bar_bank_arbiter #(
  parameter logic [1:0] BANK_ID    = 2'd0,
  parameter int         RD_CREDITS = 8
) (
  input logic                     clk_i,
  input logic                     rst_i,
  cross_bar_bank_arbiter_if.slave bus
);
  localparam int         NUM_CH = 3;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;

  logic [NUM_CH-1:0][1:0]   op;
  logic [NUM_CH-1:0][27:0]  addr;
  logic [NUM_CH-1:0][127:0] data;
  logic [NUM_CH-1:0][3:0]   credit;
  logic [NUM_CH-1:0]        elig, gnt_raw, gnt, rd_gnt, err_set;
  logic [1:0]               ptr, sel_id, sel_op;
  logic [27:0]              sel_addr;
  logic [127:0]             sel_data;
  logic                     load, htu_vld, err_q;
  logic [1:0]               ch_id_q, op_q;
  logic [27:0]              addr_q;
  logic [127:0]             data_q;
  logic [7:0]               wid_q, wtag;
  int                       idx;

  assign op   = bus.ch_req_op_i;
  assign addr = bus.ch_req_addr_i;
  assign data = bus.ch_req_data_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign elig[c]   = bus.ch_req_valid_i[c] & (addr[c][5:4] == BANK_ID) &
                       ((op[c] != OP_RD) | (credit[c] != 4'd0));
    assign rd_gnt[c] = gnt[c] & (op[c] == OP_RD);
  end

  cross_bar_bank_arbiter_credit #(.RD_CREDITS(RD_CREDITS)) u_credit [NUM_CH-1:0] (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .dec     (rd_gnt),
    .inc     (bus.rob_pop_i),
    .cnt     (credit),
    .err_set (err_set)
  );

  assign load = ~htu_vld | bus.xbar_htu_allowIn_i;

  // Walk the search order backwards so the first eligible channel from ptr wins.
  always_comb begin
    gnt_raw  = '0;
    sel_id   = '0;
    sel_op   = '0;
    sel_addr = '0;
    sel_data = '0;
    idx      = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (elig[idx]) begin
        gnt_raw      = '0;
        gnt_raw[idx] = 1'b1;
        sel_id       = 2'(idx);
        sel_op       = op[idx];
        sel_addr     = addr[idx];
        sel_data     = data[idx];
      end
    end
  end

  assign gnt            = gnt_raw & {NUM_CH{load}};
  assign bus.ch_grant_o = gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      htu_vld <= 1'b0;
      ch_id_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wid_q   <= '0;
      wtag    <= '0;
      ptr     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (|err_set) err_q <= 1'b1;
      if (load) begin
        htu_vld <= |gnt_raw;
        if (|gnt_raw) begin
          ch_id_q <= sel_id;
          op_q    <= sel_op;
          addr_q  <= sel_addr;
          data_q  <= sel_data;
          ptr     <= (sel_id == 2'd2) ? 2'd0 : sel_id + 2'd1;
          if (sel_op == OP_WR) begin
            wid_q <= wtag;
            wtag  <= wtag + 8'd1;
          end else begin
            wid_q <= 8'h00;
          end
        end
      end
    end
  end

  assign bus.xbar_htu_valid_o      = htu_vld;
  assign bus.xbar_htu_ch_id_o      = ch_id_q;
  assign bus.xbar_htu_opcode_o     = op_q;
  assign bus.xbar_htu_addr_o       = addr_q;
  assign bus.xbar_htu_data_o       = data_q;
  assign bus.xbar_htu_wbuffer_id_o = wid_q;
  assign bus.credit_err_o          = err_q;
endmodule

// File: doc/cross_bar_bank_arbiter.md
Name: cross_bar_bank_arbiter

Overview:
- Per-bank request scheduler for the cross bar; one instance per bank, selected by BANK_ID.
- Takes the three mcash channel request streams and picks the requests whose address selects this bank (addr[9:8] == BANK_ID).
- Grants one channel per cycle, round-robin, into a single registered output stage that drives the bank HTU.
- Limits outstanding reads per channel with a credit counter. Credits are returned by the channel ROB pop, so ROB entries cannot overflow.
- Issues write-buffer tags to writes.

Parameters:
- BANK_ID, 0, bank index compared against request addr[9:8].
- RD_CREDITS, 8, maximum outstanding reads per channel to this bank (1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ch_req_valid_i  in  3  per-channel request valid, bit c = channel c
- ch_req_op_i  in  6  per-channel opcode, [2c+1:2c]; 2'b00 read, 2'b01 write, others other
- ch_req_addr_i  in  84  per-channel addr[31:4], slice [28c+27:28c]
- ch_req_data_i  in  384  per-channel data, slice [128c+127:128c]
- ch_grant_o  out  3  one-hot; request of channel c accepted this cycle
- xbar_htu_valid_o  out  1  output stage valid
- xbar_htu_allowIn_i  in  1  HTU can accept
- xbar_htu_ch_id_o  out  2  granted channel
- xbar_htu_opcode_o  out  2  opcode
- xbar_htu_addr_o  out  28  addr[31:4]
- xbar_htu_data_o  out  128  data
- xbar_htu_wbuffer_id_o  out  8  write-buffer tag
- rob_pop_i  in  3  per-channel ROB pop for this bank; returns one read credit
- credit_err_o  out  1  sticky; credit returned while counter already at RD_CREDITS

Behaviour:
- Eligibility: elig[c] = ch_req_valid_i[c] & (addr_c[9:8] == BANK_ID) & (op_c != 2'b00 | credit[c] != 0).
- Load enable: load = ~xbar_htu_valid_o | xbar_htu_allowIn_i (pipe-through on handshake).
- Round-robin: pointer ptr in {0,1,2}. Search order ptr, ptr+1, ptr+2 (mod 3). The first eligible channel is granted.
- Pointer update: on a grant, ptr <= (granted+1) mod 3. With no grant, ptr holds.
- ch_grant_o is combinational: grant[c] & load. It is zero when load = 0.
- Output register update:
  - Grant with load: next cycle xbar_htu_valid_o = 1 and ch_id/opcode/addr/data are taken from the granted channel.
  - Load with no grant: xbar_htu_valid_o <= 0 and payload holds.
  - No load: all output fields hold stable.
- Read credits, per-channel 4-bit counter:
  - Granted read: -1.
  - rob_pop_i[c]: +1.
  - Both in the same cycle: unchanged.
  - Pop while counter = RD_CREDITS: counter saturates and credit_err_o <= 1 (sticky until reset).
  - Counter 0: reads from that channel are ineligible; writes and other opcodes are still eligible.
- Write tag:
  - 8-bit counter wtag.
  - Granted write: xbar_htu_wbuffer_id_o <= wtag, and wtag <= wtag+1 (wraps 8'hFF -> 8'h00).
  - Granted non-write: xbar_htu_wbuffer_id_o <= 8'h00.
- Other opcodes (2'b10, 2'b11) are arbitrated like writes but consume no credit and no tag.
- Requests for other banks are never granted and do not affect ptr.
- Reset (synchronous, takes effect mid-transfer too):
  - xbar_htu_valid_o = 0 and all payload outputs = 0.
  - ptr = 0, wtag = 0, credit[c] = RD_CREDITS, credit_err_o = 0.
  - Any in-flight output is dropped.
- Latency: request to xbar_htu_valid_o is 1 cycle. Sustained throughput is 1 request/cycle when allowIn stays high.

Test Plan:
- Ch1 read, addr[9:8] = BANK_ID = 2, allowIn = 1 -> ch_grant_o = 3'b010 in the same cycle; next cycle valid = 1, ch_id = 1, opcode = 0, credit[1] = 7.
- All three channels issue writes to this bank continuously, allowIn = 1 -> grants 001, 010, 100, 001 ...; wbuffer_id 0, 1, 2, 3 ...; after 256 writes the tag wraps to 0.
- allowIn = 0 with valid = 1 for 5 cycles while ch0 requests -> no grant, outputs hold. allowIn rises -> ch0 granted that cycle and its data appears next cycle.
- Ch2 issues 8 reads with no pops -> 9th read not granted while ch2 writes are still granted. One rob_pop_i[2] -> read granted the next cycle.
- rob_pop_i[0] with credit[0] = 8 -> credit stays 8 and credit_err_o = 1 until rst_i. Same-cycle read grant plus pop on ch0 -> credit unchanged.
- Assert rst_i while valid = 1 and allowIn = 0 -> next cycle valid = 0, ptr = 0, credits = 8. Ch0 request to BANK_ID+1 -> never granted.
